mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port RAM arbiter serving instruction and data read/write requests
module mem_responder #(
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        dhit,
  output logic [31:0] dmemload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter starts at LATENCY-1 so an access spends exactly LATENCY cycles in DACC/IACC.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ihit_q, ihit_d;
  logic        dhit_q, dhit_d;
  logic [31:0] imemload_q, imemload_d;
  logic [31:0] dmemload_q, dmemload_d;

  logic        d_active;
  assign d_active = dREN | dWEN;

  // State, wait counter, hit pulses and load registers; reset clears everything.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      imemload_q <= 32'd0;
      dmemload_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ihit_q     <= ihit_d;
      dhit_q     <= dhit_d;
      imemload_q <= imemload_d;
      dmemload_q <= dmemload_d;
    end
  end

  // Next state: data beats instruction in IDLE, dropped enables abort, counter 0 completes.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ihit_d     = 1'b0;
    dhit_d     = 1'b0;
    imemload_d = imemload_q;
    dmemload_d = dmemload_q;
    case (state_q)
      IDLE: begin
        if (d_active) begin
          state_d = DACC;
          cnt_d   = CNT_INIT;
        end else if (iREN) begin
          state_d = IACC;
          cnt_d   = CNT_INIT;
        end
      end
      DACC: begin
        if (!d_active) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = DONE;
          dhit_d  = 1'b1;
          // Writes (including read+write together) leave dmemload untouched.
          if (dREN && !dWEN) begin
            dmemload_d = ramload;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      IACC: begin
        if (!iREN) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d    = DONE;
          ihit_d     = 1'b1;
          imemload_d = ramload;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        // One dead cycle so the requester can drop its enable after the hit.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // RAM strobes follow the owning port while an access is in flight, zero otherwise.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'd0;
    ramstore = 32'd0;
    case (state_q)
      DACC: begin
        ramaddr  = daddr;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        ramstore = dstore;
      end
      IACC: begin
        ramaddr = iaddr;
        ramREN  = 1'b1;
      end
      default: begin
        ramREN   = 1'b0;
      end
    endcase
  end

  assign ihit     = ihit_q;
  assign dhit     = dhit_q;
  assign imemload = imemload_q;
  assign dmemload = dmemload_q;

endmodule
